sram_arb2: RTL and testbench
============================

SRAM_ARB2 -- requirements
Module: sram_arb2

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11: word address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1: requester n presents an access.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1: access accepted this cycle.
REQ-007 SHALL have ports req0_addr / req1_addr, input, ADDR_WIDTH: word address.
REQ-008 SHALL have ports req0_wen / req1_wen, input, WIDTH/8: byte write mask; all-zero means read.
REQ-009 SHALL have ports req0_wdata / req1_wdata, input, WIDTH: write data.
REQ-010 SHALL have ports req0_rvalid / req1_rvalid, output, 1: read data valid for requester n.
REQ-011 SHALL have port rdata, output, WIDTH: read data shared by both requesters.
REQ-012 SHALL have ports sram_wen (output, WIDTH/8), sram_ren (output, 1), sram_addr (output, ADDR_WIDTH), sram_wdata (output, WIDTH): drive a synchronous single-port byte-enabled SRAM.
REQ-013 SHALL have port sram_rdata, input, WIDTH: SRAM read data, valid one cycle after sram_ren.

Function
REQ-014 SHALL complete a transfer on port n in any cycle where reqn_valid && reqn_ready.
REQ-015 SHALL never assert req0_ready and req1_ready in the same cycle.
REQ-016 SHALL derive ready combinationally from valid: a lone valid requester is granted in the same cycle; an idle requester never gets ready.
REQ-017 SHALL arbitrate simultaneous valids round-robin: the winner is the port not served by the most recent transfer; the last-served pointer updates only on a transfer.
REQ-018 SHALL, with both requesters continuously valid, alternate grants every cycle (no starvation beyond 1 cycle).
REQ-019 SHALL drive sram_addr and sram_wdata combinationally from the granted port; sram_wen = granted wen; sram_ren = 1 only when the granted wen == 0.
REQ-020 SHALL, with no grant, drive sram_wen = 0 and sram_ren = 0; sram_addr and sram_wdata then follow port 0.
REQ-021 SHALL assert reqn_rvalid for exactly one cycle, the cycle after a read transfer on port n; writes produce no rvalid.
REQ-022 SHALL drive rdata = sram_rdata combinationally (zero latency added beyond the SRAM's 1 cycle).
REQ-023 SHALL sustain one transfer per cycle, including back-to-back reads to alternating ports (rvalid then alternates too).
REQ-024 Requesters SHALL hold valid, addr, wen and wdata stable until ready; the arbiter is not required to tolerate violations.
REQ-025 SHALL accept a write followed next cycle by a read to the same address and return the newly written data.

Reset
REQ-026 SHALL, while rst is high, hold req0_ready = req1_ready = 0, sram_wen = 0, sram_ren = 0.
REQ-027 SHALL force req0_rvalid = req1_rvalid = 0 while rst is high, and discard any pending read response, including one accepted in the cycle before rst rises.
REQ-028 SHALL reset the last-served pointer to port 1, so port 0 wins the first contended cycle after reset.
REQ-029 SHALL accept transfers in the first cycle after rst falls.

Verification
REQ-030 Single-port read: after a write on port 0 of 0xDEADBEEF to address 0x010, port 0 reads 0x010 -> req0_ready in the same cycle, req0_rvalid the next cycle with rdata = 0xDEADBEEF, req1_rvalid = 0.
REQ-031 Contention: reset, then both valid for 4 cycles with reads to 0x001 (port 0) and 0x002 (port 1) -> grants 0,1,0,1; rvalid alternates, lagging by one cycle, with the correct data.
REQ-032 Byte mask: word 0x11223344 at 0x020; port 1 writes wen = 4'b0100, wdata 0xAABBCCDD -> a later read returns 0x11BB3344.
REQ-033 Write-then-read: port 0 writes 0x5 to 0x3FF, then port 1 reads 0x3FF the next cycle -> req1_rvalid with rdata 0x00000005.
REQ-034 Reset mid-operation: port 1 read accepted, rst asserted on the next edge -> req1_rvalid never asserts; both readys 0 during reset; first contention after reset grants port 0.
REQ-035 Idle: no valids for 10 cycles -> sram_wen = 0, sram_ren = 0, no ready, no rvalid.

Source files
------------

// File: rtl/sram_arb2.sv
// sram_arb2: two-port round-robin arbiter in front of a synchronous single-port byte-enabled SRAM
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   reqN_valid/ready              per-requester handshake; transfer when both high
//   reqN_addr/wen/wdata           word address, byte write mask (all-zero = read), write data
//   reqN_rvalid                   one-cycle pulse the cycle after a read transfer on port N
//   rdata                         shared read data, straight from the SRAM
//   sram_wen/ren/addr/wdata       SRAM command for the granted port
//   sram_rdata                    SRAM read data, one cycle after sram_ren
module sram_arb2 #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WIDTH/8-1:0]    req0_wen,
    input  logic [WIDTH-1:0]      req0_wdata,
    output logic                  req0_rvalid,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WIDTH/8-1:0]    req1_wen,
    input  logic [WIDTH-1:0]      req1_wdata,
    output logic                  req1_rvalid,
    output logic [WIDTH-1:0]      rdata,
    output logic [WIDTH/8-1:0]    sram_wen,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [WIDTH-1:0]      sram_wdata,
    input  logic [WIDTH-1:0]      sram_rdata
);
    logic               last;
    logic               g0;
    logic               g1;
    logic               rv0_q;
    logic               rv1_q;
    logic [WIDTH/8-1:0] sel_wen;

    // last = port served by the most recent transfer; the other port wins contention
    always_comb begin
        g0      = !rst && req0_valid && (!req1_valid || last);
        g1      = !rst && req1_valid && (!req0_valid || !last);
        sel_wen = g1 ? req1_wen : req0_wen;
    end

    assign req0_ready = g0;
    assign req1_ready = g1;
    assign sram_addr  = g1 ? req1_addr : req0_addr;
    assign sram_wdata = g1 ? req1_wdata : req0_wdata;
    assign sram_wen   = (g0 || g1) ? sel_wen : '0;
    assign sram_ren   = (g0 || g1) && (sel_wen == '0);
    assign rdata      = sram_rdata;
    // masking with rst drops a response whose read was accepted just before rst rose
    assign req0_rvalid = rv0_q && !rst;
    assign req1_rvalid = rv1_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            last  <= 1'b1;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            last  <= g0 ? 1'b0 : (g1 ? 1'b1 : last);
            rv0_q <= g0 && (req0_wen == '0);
            rv1_q <= g1 && (req1_wen == '0);
        end
    end
endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2: table-driven check of sram_arb2 against a behavioural SRAM
module tb_sram_arb2;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [10:0] req0_addr, req1_addr;
    logic [3:0]  req0_wen, req1_wen;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_rvalid, req1_rvalid;
    logic [31:0] rdata;
    logic [3:0]  sram_wen;
    logic        sram_ren;
    logic [10:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] mem [0:2047];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_arb2 dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wen(req0_wen), .req0_wdata(req0_wdata), .req0_rvalid(req0_rvalid),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wen(req1_wen), .req1_wdata(req1_wdata), .req1_rvalid(req1_rvalid),
        .rdata(rdata), .sram_wen(sram_wen), .sram_ren(sram_ren),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        if (sram_ren) sram_rdata <= mem[sram_addr];
    end

    typedef struct {
        logic        rst, v0, v1;
        logic [10:0] a0, a1;
        logic [3:0]  w0, w1;
        logic [31:0] d0, d1;
        logic        e_r0, e_r1, e_rv0, e_rv1, chk_d;
        logic [31:0] e_d;
    } vec_t;

    vec_t v [0:17];

    function automatic vec_t mk(logic r, logic v0, logic v1, logic [10:0] a0, logic [10:0] a1,
                                logic [3:0] w0, logic [3:0] w1, logic [31:0] d0, logic [31:0] d1,
                                logic e_r0, logic e_r1, logic e_rv0, logic e_rv1,
                                logic chk_d, logic [31:0] e_d);
        vec_t t;
        t.rst = r; t.v0 = v0; t.v1 = v1; t.a0 = a0; t.a1 = a1; t.w0 = w0; t.w1 = w1;
        t.d0 = d0; t.d1 = d1; t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_rv0 = e_rv0; t.e_rv1 = e_rv1;
        t.chk_d = chk_d; t.e_d = e_d;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v0, input logic v1, input logic [10:0] a0,
                         input logic [10:0] a1, input logic [3:0] w0, input logic [3:0] w1,
                         input logic [31:0] d0, input logic [31:0] d1);
        rst = r; req0_valid = v0; req1_valid = v1; req0_addr = a0; req1_addr = a1;
        req0_wen = w0; req1_wen = w1; req0_wdata = d0; req1_wdata = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        sram_rdata = '0;
        // rst v0 v1 a0 a1 w0 w1 d0 d1 | ready0 ready1 rvalid0 rvalid1 chk_d rdata
        v[0]  = mk(0, 1, 0, 11'h010, 0, 4'hF, 0, 32'hDEADBEEF, 0,    1, 0, 0, 0, 0, 0);
        v[1]  = mk(0, 1, 0, 11'h010, 0, 4'h0, 0, 0, 0,              1, 0, 0, 0, 0, 0);
        v[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 1, 0, 1, 32'hDEADBEEF);
        v[3]  = mk(0, 1, 0, 11'h020, 0, 4'hF, 0, 32'h11223344, 0,   1, 0, 0, 0, 0, 0);
        v[4]  = mk(0, 0, 1, 0, 11'h020, 0, 4'b0100, 0, 32'hAABBCCDD, 0, 1, 0, 0, 0, 0);
        v[5]  = mk(0, 0, 1, 0, 11'h020, 0, 4'h0, 0, 0,              0, 1, 0, 0, 0, 0);
        v[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 1, 1, 32'h11BB3344);
        v[7]  = mk(0, 1, 0, 11'h3FF, 0, 4'hF, 0, 32'h5, 0,          1, 0, 0, 0, 0, 0);
        v[8]  = mk(0, 0, 1, 0, 11'h3FF, 0, 4'h0, 0, 0,              0, 1, 0, 0, 0, 0);
        v[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 1, 1, 32'h5);
        v[10] = mk(0, 0, 1, 0, 11'h002, 0, 4'hF, 0, 32'h0000B002,   0, 1, 0, 0, 0, 0);
        v[11] = mk(0, 1, 0, 11'h001, 0, 4'hF, 0, 32'h0000A001, 0,   1, 0, 0, 0, 0, 0);
        v[12] = mk(1, 1, 1, 11'h001, 11'h002, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0);
        v[13] = mk(0, 1, 1, 11'h001, 11'h002, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0);
        v[14] = mk(0, 1, 1, 11'h001, 11'h002, 0, 0, 0, 0,           0, 1, 1, 0, 1, 32'h0000A001);
        v[15] = mk(0, 1, 1, 11'h001, 11'h002, 0, 0, 0, 0,           1, 0, 0, 1, 1, 32'h0000B002);
        v[16] = mk(0, 1, 1, 11'h001, 11'h002, 0, 0, 0, 0,           0, 1, 1, 0, 1, 32'h0000A001);
        v[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 1, 1, 32'h0000B002);

        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("reset_sram", {27'd0, sram_wen, sram_ren}, 32'd0);
        next_cycle();
        next_cycle();

        for (int i = 0; i < 18; i++) begin
            drive(v[i].rst, v[i].v0, v[i].v1, v[i].a0, v[i].a1, v[i].w0, v[i].w1, v[i].d0, v[i].d1);
            @(negedge clk);
            chk($sformatf("row%0d_ready", i), {30'd0, req0_ready, req1_ready}, {30'd0, v[i].e_r0, v[i].e_r1});
            chk($sformatf("row%0d_rvalid", i), {30'd0, req0_rvalid, req1_rvalid}, {30'd0, v[i].e_rv0, v[i].e_rv1});
            if (v[i].chk_d) chk($sformatf("row%0d_rdata", i), rdata, v[i].e_d);
            next_cycle();
        end

        // port 1 read accepted, then rst on the following edge: its response must vanish
        drive(0, 0, 1, 0, 11'h002, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_rst_accept", {30'd0, req0_ready, req1_ready}, 32'd1);
        chk("mid_rst_ren", {31'd0, sram_ren}, 32'd1);
        next_cycle();
        drive(1, 1, 1, 11'h001, 11'h002, 0, 0, 0, 0);
        @(negedge clk);
        chk("in_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("in_rst_rvalid", {30'd0, req0_rvalid, req1_rvalid}, 32'd0);
        chk("in_rst_sram", {27'd0, sram_wen, sram_ren}, 32'd0);
        next_cycle();
        drive(0, 1, 1, 11'h001, 11'h002, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        chk("post_rst_rvalid", {30'd0, req0_rvalid, req1_rvalid}, 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_rv0", {30'd0, req0_rvalid, req1_rvalid}, 32'd2);
        chk("post_rst_rdata", rdata, 32'h0000A001);
        next_cycle();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i),
                {25'd0, sram_wen, sram_ren, req0_ready, req1_ready, req0_rvalid, req1_rvalid}, 32'd0);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
